// File: rtl/spi_master_mc.sv
// SPI master with per-transfer mode, SCLK divider and slave select, all latched at start.
// A transfer runs SETUP, 2*BITS_SIZE SCLK toggles in XFER, HOLD, then a one-cycle DONE.
module spi_master_mc #(
    parameter int BITS_SIZE = 8,
    parameter int NUM_SS    = 4,
    parameter int CLK_DIV_W = 8,
    localparam int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [BITS_SIZE-1:0] tx_data,
    input  logic [SS_W-1:0]      ss_sel,
    input  logic [1:0]           mode,
    input  logic [CLK_DIV_W-1:0] clk_div,
    input  logic                 MISO,
    output logic                 SCLK,
    output logic                 MOSI,
    output logic [NUM_SS-1:0]    ss_n,
    output logic                 busy,
    output logic [BITS_SIZE-1:0] rx_data,
    output logic                 tx_done,
    output logic                 rx_done
);

    localparam int EDGE_W = $clog2(2 * BITS_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t                 state_q;
    logic [CLK_DIV_W-1:0]   div_q;
    logic [CLK_DIV_W-1:0]   cnt_q;
    logic [1:0]             mode_q;
    logic [BITS_SIZE-1:0]   tx_sr_q;
    logic [BITS_SIZE-1:0]   rx_sr_q;
    logic [BITS_SIZE-1:0]   rx_data_q;
    logic [EDGE_W-1:0]      edge_q;
    logic [NUM_SS-1:0]      ss_n_q;
    logic [NUM_SS-1:0]      ss_n_d;
    logic                   sclk_q;
    logic                   mosi_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   tick;
    logic                   leading;
    logic                   last_edge;
    logic                   sample_edge;

    // Out-of-range selects decode to all-ones so the transfer runs with no slave enabled.
    function automatic logic [NUM_SS-1:0] decode_ss(input logic [SS_W-1:0] sel);
        logic [NUM_SS-1:0] ss;
        ss = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SS_W'(i)) begin
                ss[i] = 1'b0;
            end
        end
        return ss;
    endfunction

    always_comb begin
        ss_n_d = decode_ss(ss_sel);
    end

    // Even edge index is a leading edge (away from CPOL); CPHA picks which edge type samples.
    assign tick        = (cnt_q == div_q);
    assign leading     = ~edge_q[0];
    assign last_edge   = (edge_q == EDGE_W'(2 * BITS_SIZE - 1));
    assign sample_edge = mode_q[0] ? ~leading : leading;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            mode_q    <= 2'b00;
            cnt_q     <= '0;
            edge_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= mode_q[1];
                    mosi_q <= 1'b0;
                    if (tx_start) begin
                        mode_q  <= mode;
                        div_q   <= clk_div;
                        tx_sr_q <= tx_data;
                        sclk_q  <= mode[1];
                        mosi_q  <= mode[0] ? 1'b0 : tx_data[BITS_SIZE-1];
                        ss_n_q  <= ss_n_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                XFER: begin
                    if (tick) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        if (sample_edge) begin
                            rx_sr_q <= {rx_sr_q[BITS_SIZE-2:0], MISO};
                        end else if (mode_q[0]) begin
                            mosi_q  <= tx_sr_q[BITS_SIZE-1];
                            tx_sr_q <= tx_sr_q << 1;
                        end else if (!last_edge) begin
                            mosi_q  <= tx_sr_q[BITS_SIZE-2];
                            tx_sr_q <= tx_sr_q << 1;
                        end
                        if (last_edge) begin
                            edge_q  <= '0;
                            state_q <= HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cnt_q     <= '0;
                        ss_n_q    <= '1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        mosi_q    <= 1'b0;
                        rx_data_q <= rx_sr_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;
    assign rx_data = rx_data_q;
    assign tx_done = done_q;
    assign rx_done = done_q;

endmodule
